// File: rtl/save_writeback.sv
// Store engine: decodes a save instruction, reads a contiguous range of buffer lines
// and streams them as AXI4-Stream beats to the AXI write master.
module save_writeback #(
    parameter int SAVE_INST_LENGTH   = 128,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BUF_ADDR_WIDTH   = 9
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
    output logic                          save_read_buffer_a_en,
    output logic [C_BUF_ADDR_WIDTH-1:0]   save_read_buffer_a_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_a_data,
    output logic                          wr_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]  wr_size,
    input  logic                          wr_done,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast
);

    localparam int BW = C_BUF_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [BW:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_START,
        S_STREAM,
        S_WAIT_WR,
        S_DONE
    } state_t;

    state_t                          state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   offset_q;
    logic [BW-1:0]                   buf_start_q;
    logic [BW-1:0]                   line_cnt_q;
    logic [15:0]                     byte_len_q;
    logic [31:0]                     dram_addr_q;
    logic [BW:0]                     rd_cnt;
    logic [BW:0]                     push_cnt;
    logic                            inflight;
    logic                            wr_done_seen;

    // Two-entry output FIFO: the head slot drives m_axis_* straight from registers.
    logic                            out_valid;
    logic                            out_last;
    logic [DW-1:0]                   out_data;
    logic                            spare_valid;
    logic                            spare_last;
    logic [DW-1:0]                   spare_data;

    logic                            pop;
    logic                            push;
    logic                            push_last;
    logic [1:0]                      occupancy;
    logic                            room;
    logic                            reads_left;
    logic                            rd_fire;

    logic unused_inst_bits;
    assign unused_inst_bits = ^{ctrl_instruction[31:0], ctrl_instruction[79:64],
                                ctrl_instruction[63:48+BW], ctrl_instruction[47:32+BW]};

    assign pop        = out_valid & m_axis_tready;
    assign push       = inflight;
    assign push_last  = (push_cnt + CNT_ONE) == {1'b0, line_cnt_q};
    assign occupancy  = {1'b0, out_valid} + {1'b0, spare_valid} + {1'b0, inflight};
    // A read lands two edges after the decision, so reserve a slot unless the head leaves now.
    assign room       = {1'b0, occupancy} < (3'd2 + {2'b0, pop});
    assign reads_left = rd_cnt < {1'b0, line_cnt_q};

    always_comb begin
        // NOTE: assign a default before any condition so no path leaves rd_fire unassigned (no latch).
        rd_fire = 1'b0;
        if (state == S_STREAM && reads_left && room) begin
            rd_fire = 1'b1;
        end
    end

    assign save_read_buffer_a_en   = rd_fire;
    assign save_read_buffer_a_addr = buf_start_q + rd_cnt[BW-1:0];

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            state        <= S_IDLE;
            offset_q     <= '0;
            buf_start_q  <= '0;
            line_cnt_q   <= '0;
            byte_len_q   <= '0;
            dram_addr_q  <= '0;
            rd_cnt       <= '0;
            push_cnt     <= '0;
            inflight     <= 1'b0;
            wr_done_seen <= 1'b0;
            ap_done      <= 1'b0;
            wr_start     <= 1'b0;
            wr_addr      <= '0;
            wr_size      <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every register sees pre-edge values.
            ap_done  <= 1'b0;
            wr_start <= 1'b0;
            inflight <= rd_fire;
            if (rd_fire) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (inflight) begin
                push_cnt <= push_cnt + CNT_ONE;
            end
            if (wr_done && (state == S_START || state == S_STREAM)) begin
                wr_done_seen <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        offset_q     <= ctrl_addr_offset;
                        buf_start_q  <= ctrl_instruction[32 +: BW];
                        line_cnt_q   <= ctrl_instruction[48 +: BW];
                        byte_len_q   <= ctrl_instruction[95:80];
                        dram_addr_q  <= ctrl_instruction[127:96];
                        rd_cnt       <= '0;
                        push_cnt     <= '0;
                        wr_done_seen <= 1'b0;
                        state        <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    wr_addr <= offset_q + C_M_AXI_ADDR_WIDTH'(dram_addr_q);
                    wr_size <= C_XFER_SIZE_WIDTH'(byte_len_q);
                    if (line_cnt_q == '0) begin
                        ap_done <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wr_start <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (pop && out_last) begin
                        state <= S_WAIT_WR;
                    end
                end
                S_WAIT_WR: begin
                    if (wr_done || wr_done_seen) begin
                        ap_done <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            // NOTE: the FIFO data words are reset as well so m_axis_tdata reads 0 out of reset.
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            spare_valid <= 1'b0;
            spare_last  <= 1'b0;
            spare_data  <= '0;
        end else if (pop || !out_valid) begin
            if (spare_valid) begin
                out_valid   <= 1'b1;
                out_last    <= spare_last;
                out_data    <= spare_data;
                spare_valid <= push;
                spare_last  <= push & push_last;
                spare_data  <= save_read_buffer_a_data;
            end else begin
                out_valid   <= push;
                out_last    <= push & push_last;
                if (push) begin
                    out_data <= save_read_buffer_a_data;
                end
                spare_valid <= 1'b0;
            end
        end else if (push) begin
            // Head is stalled; the read guard guarantees the spare slot is free here.
            spare_valid <= 1'b1;
            spare_last  <= push_last;
            spare_data  <= save_read_buffer_a_data;
        end
    end

endmodule

// File: tb/tb_save_writeback.sv
// Self-checking bench for save_writeback: random buffer contents and addresses,
// expected beats derived from a line-range model of the save instruction.
module tb_save_writeback;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XW = 32;
    localparam int BW = 9;
    localparam int DEPTH = 512;
    localparam logic [127:0] JUNK_INST = {32'hDEAD_0000, 16'h0040, 16'h0, 16'h0002, 16'h0, 32'h0};

    logic            kernel_clk;
    logic            kernel_rst_n;
    logic            ap_start;
    logic            ap_done;
    logic [AW-1:0]   ctrl_addr_offset;
    logic [127:0]    ctrl_instruction;
    logic            save_read_buffer_a_en;
    logic [BW-1:0]   save_read_buffer_a_addr;
    logic [DW-1:0]   save_read_buffer_a_data;
    logic            wr_start;
    logic [AW-1:0]   wr_addr;
    logic [XW-1:0]   wr_size;
    logic            wr_done;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tlast;

    save_writeback dut (
        .kernel_clk              (kernel_clk),
        .kernel_rst_n            (kernel_rst_n),
        .ap_start                (ap_start),
        .ap_done                 (ap_done),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_instruction        (ctrl_instruction),
        .save_read_buffer_a_en   (save_read_buffer_a_en),
        .save_read_buffer_a_addr (save_read_buffer_a_addr),
        .save_read_buffer_a_data (save_read_buffer_a_data),
        .wr_start                (wr_start),
        .wr_addr                 (wr_addr),
        .wr_size                 (wr_size),
        .wr_done                 (wr_done),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tready           (m_axis_tready),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tlast            (m_axis_tlast)
    );

    initial kernel_clk = 1'b0;
    always #5 kernel_clk = ~kernel_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge kernel_clk) cyc <= cyc + 1;

    // Buffer model: data appears the cycle after en.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge kernel_clk) begin
        if (save_read_buffer_a_en) save_read_buffer_a_data <= mem[save_read_buffer_a_addr];
    end

    // Observation state, cleared before each operation.
    logic [BW-1:0] rd_q [$];
    logic [DW-1:0] beat_d [$];
    logic          beat_l [$];
    int            ws_cnt, ws_cyc, ad_cnt, ad_cyc, first_en_cyc, first_tv_cyc, last_beat_cyc, stall_err;
    logic [AW-1:0] ws_addr;
    logic [XW-1:0] ws_size;
    logic          stall_pend;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    int            t0, w_cyc;

    always @(negedge kernel_clk) begin
        if (!kernel_rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (save_read_buffer_a_en) begin
                rd_q.push_back(save_read_buffer_a_addr);
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            if (wr_start) begin
                ws_cnt++;
                ws_cyc = cyc;
                ws_addr = wr_addr;
                ws_size = wr_size;
            end
            if (ap_done) begin
                ad_cnt++;
                ad_cyc = cyc;
            end
            if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
            if (stall_pend && !(m_axis_tvalid === 1'b1 && m_axis_tdata === stall_data
                                && m_axis_tlast === stall_last)) stall_err++;
            stall_pend = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_d.push_back(m_axis_tdata);
                beat_l.push_back(m_axis_tlast);
                last_beat_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        beat_d.delete();
        beat_l.delete();
        ws_cnt = 0; ws_cyc = -1; ad_cnt = 0; ad_cyc = -1;
        first_en_cyc = -1; first_tv_cyc = -1; last_beat_cyc = -1; stall_err = 0;
        ws_addr = '0; ws_size = '0;
    endtask

    task automatic tick();
        @(posedge kernel_clk);
        #1;
    endtask

    task automatic launch(input int start, input int n, input int bytes,
                          input logic [31:0] dram, input logic [AW-1:0] off);
        logic [127:0] inst;
        clear_mon();
        tick();
        inst = '0;
        inst[47:32]  = 16'(start);
        inst[63:48]  = 16'(n);
        inst[95:80]  = 16'(bytes);
        inst[127:96] = dram;
        ctrl_addr_offset = off;
        ctrl_instruction = inst;
        ap_start = 1'b1;
        t0 = cyc;
        tick();
        ap_start = 1'b0;
    endtask

    // mode 0: tready high; mode 1: random tready with a 10-cycle stall.
    task automatic stream(input int n, input int mode, input bit early);
        int k;
        k = 0;
        while (beat_d.size() < n && k < 400) begin
            if (mode == 0) m_axis_tready = 1'b1;
            else if (k >= 8 && k < 18) m_axis_tready = 1'b0;
            else m_axis_tready = 1'($urandom_range(0, 1));
            wr_done  = early && (cyc == t0 + 5);
            ap_start = early && (cyc == t0 + 7);
            if (ap_start) ctrl_instruction = JUNK_INST;
            tick();
            k++;
        end
        wr_done = 1'b0;
        ap_start = 1'b0;
        m_axis_tready = 1'b1;
        check("stream_complete", DW'(beat_d.size()), DW'(n));
    endtask

    task automatic finish_xfer(input bit send_wr_done);
        if (send_wr_done) begin
            tick();
            tick();
            wr_done = 1'b1;
            w_cyc = cyc;
            tick();
            wr_done = 1'b0;
        end
        for (int k = 0; k < 20 && ad_cnt == 0; k++) tick();
        repeat (6) tick();
    endtask

    task automatic check_beats(input string name, input int start, input int n);
        check({name, "_read_count"}, DW'(rd_q.size()), DW'(n));
        check({name, "_beat_count"}, DW'(beat_d.size()), DW'(n));
        for (int i = 0; i < n; i++) begin
            int a;
            a = (start + i) % DEPTH;
            if (i < rd_q.size())
                check($sformatf("%s_rd_addr%0d", name, i), DW'(rd_q[i]), DW'(a));
            if (i < beat_d.size()) begin
                check($sformatf("%s_beat%0d_data", name, i), beat_d[i], mem[a]);
                check($sformatf("%s_beat%0d_last", name, i), DW'(beat_l[i]), DW'(i == n - 1));
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ap_done"}, DW'(ap_done), '0);
        check({name, "_wr_start"}, DW'(wr_start), '0);
        check({name, "_en"}, DW'(save_read_buffer_a_en), '0);
        check({name, "_tvalid"}, DW'(m_axis_tvalid), '0);
        check({name, "_tlast"}, DW'(m_axis_tlast), '0);
        check({name, "_rd_addr"}, DW'(save_read_buffer_a_addr), '0);
        check({name, "_wr_addr"}, DW'(wr_addr), '0);
        check({name, "_wr_size"}, DW'(wr_size), '0);
        check({name, "_tdata"}, m_axis_tdata, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        logic [AW-1:0] off;
        logic [31:0] dram;

        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DW / 32; j++) mem[i][j*32 +: 32] = $urandom;
        kernel_rst_n = 1'b0;
        ap_start = 1'b0;
        wr_done = 1'b0;
        m_axis_tready = 1'b0;
        ctrl_addr_offset = '0;
        ctrl_instruction = '0;
        save_read_buffer_a_data = '0;
        stall_pend = 1'b0;
        clear_mon();
        repeat (3) tick();
        check_outputs_zero("reset");
        kernel_rst_n = 1'b1;
        repeat (2) tick();

        // Basic transfer with exact cycle timing.
        launch(16'h010, 4, 256, 32'h0000_1000, 64'h0000_0000_8000_0000);
        stream(4, 0, 1'b0);
        finish_xfer(1'b1);
        check("basic_wr_addr", DW'(ws_addr), DW'(64'h0000_0000_8000_1000));
        check("basic_wr_size", DW'(ws_size), DW'(256));
        check("basic_wr_start_cnt", DW'(ws_cnt), DW'(1));
        check("basic_wr_start_cyc", DW'(ws_cyc), DW'(t0 + 2));
        check("basic_first_en_cyc", DW'(first_en_cyc), DW'(t0 + 3));
        check("basic_first_tvalid_cyc", DW'(first_tv_cyc), DW'(t0 + 5));
        check("basic_last_beat_cyc", DW'(last_beat_cyc), DW'(t0 + 8));
        check("basic_ap_done_cnt", DW'(ad_cnt), DW'(1));
        check("basic_ap_done_cyc", DW'(ad_cyc), DW'(w_cyc + 1));
        check_beats("basic", 16'h010, 4);

        // Address wrap 511 -> 0.
        launch(16'h1FE, 4, 256, $urandom, {$urandom, $urandom});
        stream(4, 0, 1'b0);
        finish_xfer(1'b1);
        check_beats("wrap", 16'h1FE, 4);
        check("wrap_ap_done_cnt", DW'(ad_cnt), DW'(1));

        // Backpressure with random tready and a long stall.
        start = $urandom_range(0, DEPTH - 1);
        off = {$urandom, $urandom};
        dram = $urandom;
        launch(start, 8, 512, dram, off);
        stream(8, 1, 1'b0);
        finish_xfer(1'b1);
        check_beats("bp", start, 8);
        check("bp_stall_stable", DW'(stall_err), '0);
        check("bp_wr_addr", DW'(ws_addr), DW'(off + {32'h0, dram}));
        check("bp_ap_done_cnt", DW'(ad_cnt), DW'(1));

        // Zero length: straight to done.
        launch($urandom_range(0, DEPTH - 1), 0, 0, $urandom, {$urandom, $urandom});
        finish_xfer(1'b0);
        check("zero_wr_start_cnt", DW'(ws_cnt), '0);
        check("zero_read_count", DW'(rd_q.size()), '0);
        check("zero_beat_count", DW'(beat_d.size()), '0);
        check("zero_ap_done_cnt", DW'(ad_cnt), DW'(1));
        check("zero_ap_done_cyc", DW'(ad_cyc), DW'(t0 + 2));

        // Early wr_done and a stray ap_start during STREAM.
        start = $urandom_range(0, DEPTH - 1);
        off = {$urandom, $urandom};
        dram = $urandom;
        launch(start, 8, 512, dram, off);
        stream(8, 0, 1'b1);
        finish_xfer(1'b0);
        check_beats("early", start, 8);
        check("early_wr_addr", DW'(ws_addr), DW'(off + {32'h0, dram}));
        check("early_wr_size", DW'(ws_size), DW'(512));
        check("early_wr_start_cnt", DW'(ws_cnt), DW'(1));
        check("early_ap_done_cnt", DW'(ad_cnt), DW'(1));
        check("early_ap_done_cyc", DW'(ad_cyc), DW'(last_beat_cyc + 2));

        // Reset in the middle of a burst.
        launch($urandom_range(0, DEPTH - 1), 8, 512, $urandom, {$urandom, $urandom});
        m_axis_tready = 1'b1;
        for (int k = 0; k < 40 && beat_d.size() < 3; k++) tick();
        check("midrst_reached_beat3", DW'(beat_d.size()), DW'(3));
        #2;
        kernel_rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (3) tick();
        kernel_rst_n = 1'b1;
        clear_mon();
        repeat (6) tick();
        check("midrst_no_ap_done", DW'(ad_cnt), '0);

        start = $urandom_range(0, DEPTH - 1);
        off = {$urandom, $urandom};
        dram = $urandom;
        launch(start, 5, 320, dram, off);
        stream(5, 0, 1'b0);
        finish_xfer(1'b1);
        check_beats("postrst", start, 5);
        check("postrst_wr_addr", DW'(ws_addr), DW'(off + {32'h0, dram}));
        check("postrst_ap_done_cyc", DW'(ad_cyc), DW'(w_cyc + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
